multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle control FSM that sequences the RV32 subset datapath: R-type add/sub/and/or, lw, sw and beq.
- Fetch, decode, execute, memory and write-back run in separate cycles over one shared ALU and one shared instruction/data memory port.
- Emits per-state datapath strobes and runs a req/ready handshake with memory.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction_i  input  32  contents of the instruction register, valid from DECODE onward.
- zero_i  input  1  ALU zero flag.
- mem_ready_i  input  1  memory completes the current request this cycle.
- mem_req_o  output  1  memory request.
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALU result.
- MemRead_o  output  1  memory read strobe.
- MemWrite_o  output  1  memory write strobe.
- IRWrite_o  output  1  load the instruction register.
- PCWrite_o  output  1  update PC.
- PCSrc_o  output  1  PC source: 0 = PC+4, 1 = branch target.
- ALUsrc_o  output  1  ALU operand B: 0 = register, 1 = immediate.
- ALUControl_o  output  4  ALU operation.
- RegWrite_o  output  1  register file write strobe.
- MemToReg_o  output  1  write-back source: 1 = memory data, 0 = ALU.
- illegal_o  output  1  sticky unsupported-instruction flag.
- state_o  output  3  current state encoding.
- retired_o  output  CNT_W  number of retired instructions.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Outputs decode combinationally from the state register, instruction_i, mem_ready_i and zero_i. Every strobe defaults to 0.
- Reset (asynchronous, active-high):
  - State goes to FETCH and retired_o to 0; illegal_o clears.
  - While rst=1, every output is forced to 0, state_o included.
  - A reset mid-instruction aborts it with no further writes.
  - The first clock after release is a FETCH cycle.
- FETCH:
  - mem_req_o=1, MemRead_o=1, IorD_o=0, held until mem_ready_i.
  - In the mem_ready_i cycle: IRWrite_o=1, PCWrite_o=1, PCSrc_o=0, ALUControl_o=0010 (PC+4), then go to DECODE.
- DECODE: no strobes; classifies instruction_i[6:0].
  - 0x03, 0x23: go to EXEC; funct3 is ignored.
  - 0x33: legal combos are funct7=0x00 with funct3 000/111/110, and funct7=0x20 with funct3 000. Legal go to EXEC; any other combo goes to HALT.
  - 0x63: funct3=000 goes to EXEC, else HALT.
  - Any other opcode goes to HALT.
- EXEC:
  - lw/sw: ALUsrc_o=1, ALUControl_o=0010, then go to MEM.
  - R-type: ALUsrc_o=0; ALUControl_o is add 0010, sub 0110, and 0000, or 0001; then go to WB.
  - beq: ALUsrc_o=0, ALUControl_o=0110, PCSrc_o=1, PCWrite_o=zero_i. Retired++, then go to FETCH.
- MEM:
  - mem_req_o=1, IorD_o=1, ALUsrc_o=1, ALUControl_o=0010.
  - MemRead_o=1 for lw; MemWrite_o=1 for sw, asserted every cycle until mem_ready_i.
  - On mem_ready_i: lw goes to WB; sw retires (retired++) and goes to FETCH.
- WB: RegWrite_o=1 for exactly one cycle. MemToReg_o=1 for lw, 0 for R-type. Retired++, then go to FETCH.
- HALT:
  - illegal_o=1, no strobes, mem_req_o=0.
  - Stays in HALT until rst.
- Handshake rules:
  - mem_req_o and its qualifiers (IorD_o, MemRead_o, MemWrite_o) stay stable while waiting.
  - A zero-wait response (mem_ready_i high in the first request cycle) completes in that cycle.
  - mem_ready_i is ignored whenever mem_req_o=0.
- Retired counter:
  - Increments exactly once per instruction, on the state-leaving edge of its last state.
  - Wraps modulo 2^CNT_W.
  - Illegal instructions do not count.
- Latency with zero-wait memory: R-type 4 cycles, lw 5, sw 4, beq 3.
- Write exclusivity: RegWrite_o and MemWrite_o are never asserted together, and never outside WB and MEM respectively.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready_i tied 1 -> state_o sequence 0,1,2,4,0. ALUControl_o=0010 in EXEC. RegWrite_o=1 and MemToReg_o=0 for one cycle in WB. retired_o=1.
- lw x3,0(x1) (0x0000A183), mem_ready_i delayed 3 cycles in MEM -> MEM lasts 4 cycles with mem_req_o, MemRead_o and IorD_o held at 1. Then WB with MemToReg_o=1. retired_o increments after WB.
- sw x2,0(x1) (0x0020A023) -> MemWrite_o=1 throughout MEM until ready. RegWrite_o stays 0. Returns to FETCH after 4 cycles total.
- beq x1,x2,8 (0x00208463):
  - zero_i=1 -> EXEC has PCWrite_o=1, PCSrc_o=1, ALUControl_o=0110.
  - Repeat with zero_i=0 -> PCWrite_o=0.
  - Both take 3 cycles.
- addi (0x00000013) and R-type with funct7=0x01 (0x022081B3) -> HALT after DECODE, illegal_o=1 sticky, no mem_req_o, retired_o unchanged. rst clears illegal_o.
- rst pulsed mid-MEM of sw while waiting for mem_ready_i -> all outputs drop to 0 immediately without a clock edge, MemWrite_o is never asserted again, retired_o=0, FETCH restarts after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multi-cycle RV32 subset datapath
// (add/sub/and/or, lw, sw, beq). One shared ALU and one shared memory port.
// Strobes decode combinationally from the state register and the current
// inputs. A retired-instruction counter and a sticky illegal flag are kept.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCSrc_o,
  output logic             ALUsrc_o,
  output logic [3:0]       ALUControl_o,
  output logic             RegWrite_o,
  output logic             MemToReg_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t           r_state;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;

  // Instruction field decode
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_rtype;
  logic       w_is_branch;
  logic       w_r_legal;
  logic       w_b_legal;
  logic       w_legal;
  logic [3:0] w_r_alu;
  logic       w_unused_instr;

  assign w_opcode    = instruction_i[6:0];
  assign w_funct3    = instruction_i[14:12];
  assign w_funct7    = instruction_i[31:25];
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_rtype  = (w_opcode == OP_RTYPE);
  assign w_is_branch = (w_opcode == OP_BRANCH);

  // Register indices are datapath business; the controller never looks at them.
  assign w_unused_instr = ^{instruction_i[24:15], instruction_i[11:7]};

  assign w_r_legal = w_is_rtype &&
                     (((w_funct7 == 7'h00) && ((w_funct3 == 3'b000) ||
                                               (w_funct3 == 3'b111) ||
                                               (w_funct3 == 3'b110))) ||
                      ((w_funct7 == 7'h20) && (w_funct3 == 3'b000)));
  assign w_b_legal = w_is_branch && (w_funct3 == 3'b000);
  assign w_legal   = w_is_load || w_is_store || w_r_legal || w_b_legal;

  // R-type ALU operation select from funct3/funct7
  always_comb begin
    w_r_alu = ALU_ADD;
    unique case (w_funct3)
      3'b000:  w_r_alu = w_funct7[5] ? ALU_SUB : ALU_ADD;
      3'b111:  w_r_alu = ALU_AND;
      3'b110:  w_r_alu = ALU_OR;
      default: w_r_alu = ALU_ADD;
    endcase
  end

  // Unqualified strobes and next-state, before reset gating
  state_t     w_next;
  logic       w_retire;
  logic       w_mem_req;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_alu_src;
  logic [3:0] w_alu_ctl;
  logic       w_reg_write;
  logic       w_mem_to_reg;

  // Per-state strobe decode and next-state selection
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_mem_req    = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_ctl    = '0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_mem_read = 1'b1;
        if (mem_ready_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_alu_ctl  = ALU_ADD;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = w_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_alu_src = 1'b1;
          w_alu_ctl = ALU_ADD;
          w_next    = S_MEM;
        end else if (w_is_branch) begin
          w_alu_ctl  = ALU_SUB;
          w_pc_src   = 1'b1;
          w_pc_write = zero_i;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else begin
          w_alu_ctl = w_r_alu;
          w_next    = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_iord      = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctl   = ALU_ADD;
        w_mem_read  = w_is_load;
        w_mem_write = ~w_is_load;
        if (mem_ready_i) begin
          if (w_is_load) begin
            w_next = S_WB;
          end else begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_load;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State, retired counter and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_next == S_HALT) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // FETCH is encoded as 0 but drives strobes, so every output is gated by rst
  // to go quiet immediately, without waiting for a clock edge.
  assign mem_req_o    = w_mem_req    & ~rst;
  assign IorD_o       = w_iord       & ~rst;
  assign MemRead_o    = w_mem_read   & ~rst;
  assign MemWrite_o   = w_mem_write  & ~rst;
  assign IRWrite_o    = w_ir_write   & ~rst;
  assign PCWrite_o    = w_pc_write   & ~rst;
  assign PCSrc_o      = w_pc_src     & ~rst;
  assign ALUsrc_o     = w_alu_src    & ~rst;
  assign ALUControl_o = w_alu_ctl    & {4{~rst}};
  assign RegWrite_o   = w_reg_write  & ~rst;
  assign MemToReg_o   = w_mem_to_reg & ~rst;
  assign illegal_o    = r_illegal    & ~rst;
  assign state_o      = r_state      & {3{~rst}};
  assign retired_o    = r_retired    & {CNT_W{~rst}};

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench. Each instruction is expanded into
// its expected per-cycle output vectors (with the inputs for that cycle) and
// queued; the driver pops one entry per cycle, drives it and compares.
module tb_multicycle_controller;

  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst;
  logic [31:0]   instruction_i;
  logic          zero_i;
  logic          mem_ready_i;
  logic          mem_req_o;
  logic          IorD_o;
  logic          MemRead_o;
  logic          MemWrite_o;
  logic          IRWrite_o;
  logic          PCWrite_o;
  logic          PCSrc_o;
  logic          ALUsrc_o;
  logic [3:0]    ALUControl_o;
  logic          RegWrite_o;
  logic          MemToReg_o;
  logic          illegal_o;
  logic [2:0]    state_o;
  logic [CW-1:0] retired_o;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction_i(instruction_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .IorD_o       (IorD_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .IRWrite_o    (IRWrite_o),
    .PCWrite_o    (PCWrite_o),
    .PCSrc_o      (PCSrc_o),
    .ALUsrc_o     (ALUsrc_o),
    .ALUControl_o (ALUControl_o),
    .RegWrite_o   (RegWrite_o),
    .MemToReg_o   (MemToReg_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o),
    .retired_o    (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic        iord;
    logic        mrd;
    logic        mwr;
    logic        irw;
    logic        pcw;
    logic        pcs;
    logic        alusrc;
    logic [3:0]  alu;
    logic        rw;
    logic        m2r;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [31:0] instr;
    exp_t        e;
  } stim_t;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

  stim_t       q_stim[$];
  string       q_tag[$];
  int          n_cmp;
  int          n_err;
  logic [31:0] m_ret;
  logic        m_ill;
  exp_t        w_obs;

  always_comb begin
    w_obs        = '0;
    w_obs.st     = state_o;
    w_obs.req    = mem_req_o;
    w_obs.iord   = IorD_o;
    w_obs.mrd    = MemRead_o;
    w_obs.mwr    = MemWrite_o;
    w_obs.irw    = IRWrite_o;
    w_obs.pcw    = PCWrite_o;
    w_obs.pcs    = PCSrc_o;
    w_obs.alusrc = ALUsrc_o;
    w_obs.alu    = ALUControl_o;
    w_obs.rw     = RegWrite_o;
    w_obs.m2r    = MemToReg_o;
    w_obs.ill    = illegal_o;
    w_obs.ret    = 32'(retired_o);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.ill = m_ill;
    e.ret = m_ret;
    return e;
  endfunction

  task automatic push(input string tag, input logic rdy, input logic z,
                      input logic [31:0] ins, input exp_t e);
    stim_t s;
    s.rdy   = rdy;
    s.z     = z;
    s.instr = ins;
    s.e     = e;
    q_stim.push_back(s);
    q_tag.push_back(tag);
  endtask

  function automatic logic [31:0] inc_ret(input logic [31:0] v);
    return (v + 32'd1) & ((32'd1 << CW) - 32'd1);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction. fw/mw are memory
  // wait cycles in FETCH/MEM; cut stops inside MEM before the ready cycle.
  task automatic push_instr(input string nm, input kind_t kind, input logic [31:0] ins,
                            input int fw, input int mw, input logic z,
                            input logic [3:0] ralu, input bit cut);
    exp_t e;
    for (int i = 0; i < fw; i++) begin
      e = mk(3'd0); e.req = 1; e.mrd = 1;
      push({nm, ".fetch_wait"}, 1'b0, z, ins, e);
    end
    e = mk(3'd0); e.req = 1; e.mrd = 1; e.irw = 1; e.pcw = 1; e.alu = 4'b0010;
    push({nm, ".fetch"}, 1'b1, z, ins, e);
    e = mk(3'd1);
    push({nm, ".decode"}, 1'($urandom_range(0, 1)), z, ins, e);
    case (kind)
      K_R: begin
        e = mk(3'd2); e.alu = ralu;
        push({nm, ".exec"}, 1'($urandom_range(0, 1)), z, ins, e);
        e = mk(3'd4); e.rw = 1;
        push({nm, ".wb"}, 1'($urandom_range(0, 1)), z, ins, e);
        m_ret = inc_ret(m_ret);
      end
      K_LW, K_SW: begin
        e = mk(3'd2); e.alusrc = 1; e.alu = 4'b0010;
        push({nm, ".exec"}, 1'($urandom_range(0, 1)), z, ins, e);
        e = mk(3'd3); e.req = 1; e.iord = 1; e.alusrc = 1; e.alu = 4'b0010;
        e.mrd = (kind == K_LW); e.mwr = (kind == K_SW);
        for (int i = 0; i < mw; i++) push({nm, ".mem_wait"}, 1'b0, z, ins, e);
        if (!cut) begin
          push({nm, ".mem"}, 1'b1, z, ins, e);
          if (kind == K_LW) begin
            e = mk(3'd4); e.rw = 1; e.m2r = 1;
            push({nm, ".wb"}, 1'($urandom_range(0, 1)), z, ins, e);
          end
          m_ret = inc_ret(m_ret);
        end
      end
      K_BEQ: begin
        e = mk(3'd2); e.alu = 4'b0110; e.pcs = 1; e.pcw = z;
        push({nm, ".exec"}, 1'($urandom_range(0, 1)), z, ins, e);
        m_ret = inc_ret(m_ret);
      end
      default: begin
        m_ill = 1'b1;
        for (int i = 0; i < 3; i++) begin
          e = mk(3'd5);
          push({nm, ".halt"}, 1'b1, z, ins, e);
        end
      end
    endcase
  endtask

  // Drain the queue one entry per cycle: drive 1 after the edge, compare mid-cycle.
  task automatic run_queue(input bit first);
    stim_t s;
    string t;
    bit    f;
    f = first;
    while (q_stim.size() > 0) begin
      if (!f) begin
        @(posedge clk);
        #1;
      end
      f = 1'b0;
      s = q_stim.pop_front();
      t = q_tag.pop_front();
      mem_ready_i   = s.rdy;
      zero_i        = s.z;
      instruction_i = s.instr;
      #3;
      check(t, 64'(w_obs), 64'(s.e));
    end
  endtask

  // Assert reset without a clock edge, check outputs drop, hold, then release
  // just after an edge so the following cycle is the first FETCH.
  task automatic reset_and_release(input string tag);
    rst         = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    check({tag, ".async"}, 64'(w_obs), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, 64'(w_obs), 64'd0);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ret = '0;
    m_ill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    m_ret         = '0;
    m_ill         = 1'b0;
    rst           = 1'b1;
    mem_ready_i   = 1'b1;
    zero_i        = 1'b0;
    instruction_i = 32'h002081B3;
    #2;

    // Legal mix with wait states; CW=3 so the counter wraps after eight.
    reset_and_release("reset0");
    push_instr("add",   K_R,   32'h002081B3, 0, 0, 1'b0, 4'b0010, 0);
    push_instr("lw",    K_LW,  32'h0000A183, 1, 3, 1'b0, 4'b0000, 0);
    push_instr("sw",    K_SW,  32'h0020A023, 0, 0, 1'b0, 4'b0000, 0);
    push_instr("beq_t", K_BEQ, 32'h00208463, 0, 0, 1'b1, 4'b0000, 0);
    push_instr("beq_n", K_BEQ, 32'h00208463, 0, 0, 1'b0, 4'b0000, 0);
    push_instr("sub",   K_R,   32'h402081B3, 0, 0, 1'b1, 4'b0110, 0);
    push_instr("and",   K_R,   32'h0020F1B3, 2, 0, 1'b0, 4'b0000, 0);
    push_instr("or",    K_R,   32'h0020E1B3, 0, 0, 1'b0, 4'b0001, 0);
    push_instr("lw0",   K_LW,  32'h0000A183, 0, 0, 1'b0, 4'b0000, 0);
    push_instr("sw2",   K_SW,  32'h0020A023, 2, 2, 1'b0, 4'b0000, 0);
    run_queue(1'b1);

    // addi is unsupported: HALT, sticky flag, no requests.
    reset_and_release("reset1");
    push_instr("addi",  K_ILL, 32'h00000013, 0, 0, 1'b0, 4'b0000, 0);
    run_queue(1'b1);

    // Retired count survives into HALT; bad funct7 is illegal.
    reset_and_release("reset2");
    push_instr("add2",  K_R,   32'h002081B3, 0, 0, 1'b0, 4'b0010, 0);
    push_instr("f7_01", K_ILL, 32'h022081B3, 0, 0, 1'b0, 4'b0000, 0);
    run_queue(1'b1);

    reset_and_release("reset3");
    push_instr("bne",   K_ILL, 32'h00209463, 1, 0, 1'b0, 4'b0000, 0);
    run_queue(1'b1);

    // Reset while sw waits in MEM: aborts, counter clears, FETCH restarts.
    reset_and_release("reset4");
    push_instr("add3",  K_R,   32'h002081B3, 0, 0, 1'b0, 4'b0010, 0);
    push_instr("sw_ab", K_SW,  32'h0020A023, 0, 2, 1'b0, 4'b0000, 1);
    run_queue(1'b1);
    reset_and_release("abort");
    push_instr("add4",  K_R,   32'h002081B3, 0, 0, 1'b0, 4'b0010, 0);
    push_instr("sw4",   K_SW,  32'h0020A023, 0, 1, 1'b0, 4'b0000, 0);
    run_queue(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
